// File: rtl/adpll_chan_seq.sv
// -----------------------------------------------------------------------------
// adpll_chan_seq
//   Channel-hop sequencer for the ADPLL controller. Takes channel/mode
//   requests over a valid/ready handshake. For each request it drives
//   adpll_mode to PD for a fixed gap so the ADPLL FSM restarts cleanly. It
//   then applies the new FCW and mode and waits for channel_lock. Lock
//   acquisition, timeout, lock loss and bad requests are reported to the host.
//   All state updates happen on the falling edge of clk, the same edge the
//   ADPLL controller uses.
//
//   Optional build macro: ADPLL_SEQ_RETRY_EN
//     When defined, the first WAIT_LOCK timeout of a request re-runs the PD
//     gap with the same channel/mode and raises no error. A second timeout
//     reports the error as usual.
// -----------------------------------------------------------------------------
module adpll_chan_seq #(
    parameter logic [25:0] FCW_BASE = 26'd1229824,  // channel 0, 12.14 fixed point
    parameter logic [25:0] FCW_STEP = 26'd1024,     // 2 MHz channel spacing
    parameter logic [5:0]  MAX_CHAN = 6'd39,
    parameter int          GAP_CYC  = 4,            // PD cycles before apply, >= 2
    parameter int          TMO_CYC  = 1024          // WAIT_LOCK timeout in cycles
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_chan,
    input  logic [1:0]  req_mode,
    input  logic        channel_lock,
    output logic [25:0] fcw,
    output logic [1:0]  adpll_mode,
    output logic        busy,
    output logic        locked,
    output logic        done_pulse,
    output logic        err_pulse,
    output logic [1:0]  err_code,
    output logic [5:0]  cur_chan
);

    localparam int GAP_W = $clog2(GAP_CYC);
    localparam int TMR_W = $clog2(TMO_CYC) + 1;

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TMO_CYC - 1);

    localparam logic [1:0] MODE_PD   = 2'd0;
    localparam logic [1:0] MODE_TEST = 2'd1;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_TMO  = 2'd1;
    localparam logic [1:0] ERR_BAD  = 2'd2;
    localparam logic [1:0] ERR_LOST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_WAIT_LOCK,
        ST_LOCKED
    } state_e;

    // Registered state
    state_e           state;
    logic [5:0]       chan_lat;
    logic [1:0]       mode_lat;
    logic [GAP_W-1:0] gap_cnt;
    logic [TMR_W-1:0] timer;
    logic             arm;
`ifdef ADPLL_SEQ_RETRY_EN
    logic             retried;
`endif

    // Next-state values
    state_e           state_n;
    logic [25:0]      fcw_n;
    logic [1:0]       mode_n;
    logic [5:0]       cur_chan_n;
    logic [5:0]       chan_lat_n;
    logic [1:0]       mode_lat_n;
    logic [GAP_W-1:0] gap_cnt_n;
    logic [TMR_W-1:0] timer_n;
    logic             arm_n;
    logic             done_n;
    logic             err_p_n;
    logic [1:0]       err_code_n;
`ifdef ADPLL_SEQ_RETRY_EN
    logic             retried_n;
`endif

    logic        handshake;
    logic        req_bad;
    logic [25:0] fcw_calc;

    assign req_ready = (state == ST_IDLE) || (state == ST_LOCKED);
    assign busy      = (state == ST_GAP) || (state == ST_WAIT_LOCK);
    assign locked    = (state == ST_LOCKED);
    assign handshake = req_valid && req_ready;
    assign req_bad   = (req_chan > MAX_CHAN) || (req_mode == MODE_TEST);

    // The product wraps mod 2^26; the parameter range keeps it from wrapping.
    assign fcw_calc  = FCW_BASE + (26'(chan_lat) * FCW_STEP);

    // Next-state and output decode for the sequencer FSM
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_n    = state;
        fcw_n      = fcw;
        mode_n     = adpll_mode;
        cur_chan_n = cur_chan;
        chan_lat_n = chan_lat;
        mode_lat_n = mode_lat;
        gap_cnt_n  = gap_cnt;
        timer_n    = timer;
        arm_n      = arm;
        done_n     = 1'b0;
        err_p_n    = 1'b0;
        err_code_n = err_code;
`ifdef ADPLL_SEQ_RETRY_EN
        retried_n  = retried;
`endif

        case (state)
            ST_IDLE, ST_LOCKED: begin
                if (handshake) begin
                    if (req_bad) begin
                        // Rejected: only the error status changes.
                        err_p_n    = 1'b1;
                        err_code_n = ERR_BAD;
                    end else if (req_mode == MODE_PD) begin
                        mode_n     = MODE_PD;
                        err_code_n = ERR_NONE;
                        state_n    = ST_IDLE;
`ifdef ADPLL_SEQ_RETRY_EN
                        retried_n  = 1'b0;
`endif
                    end else begin
                        // RX/TX: always re-sequenced, even if unchanged.
                        chan_lat_n = req_chan;
                        mode_lat_n = req_mode;
                        err_code_n = ERR_NONE;
                        mode_n     = MODE_PD;
                        gap_cnt_n  = GAP_LOAD;
                        state_n    = ST_GAP;
`ifdef ADPLL_SEQ_RETRY_EN
                        retried_n  = 1'b0;
`endif
                    end
                end else if ((state == ST_LOCKED) && !channel_lock) begin
                    // Lock lost: keep fcw/mode, re-supervise from scratch.
                    err_p_n    = 1'b1;
                    err_code_n = ERR_LOST;
                    timer_n    = '0;
                    arm_n      = 1'b0;
                    state_n    = ST_WAIT_LOCK;
                end
            end

            ST_GAP: begin
                if (gap_cnt == '0) begin
                    mode_n     = mode_lat;
                    cur_chan_n = chan_lat;
                    timer_n    = '0;
                    arm_n      = 1'b0;
                    state_n    = ST_WAIT_LOCK;
                end else begin
                    gap_cnt_n = gap_cnt - GAP_W'(1);
                    // FCW settles one cycle ahead of the mode change.
                    if (gap_cnt == GAP_W'(1)) begin
                        fcw_n = fcw_calc;
                    end
                end
            end

            ST_WAIT_LOCK: begin
                // A lock already high on entry is stale until it has been seen low.
                if (!channel_lock) begin
                    arm_n = 1'b1;
                end
                if (arm && channel_lock) begin
                    done_n  = 1'b1;
                    state_n = ST_LOCKED;
                end else if (timer == TMO_LAST) begin
`ifdef ADPLL_SEQ_RETRY_EN
                    if (!retried) begin
                        retried_n = 1'b1;
                        mode_n    = MODE_PD;
                        gap_cnt_n = GAP_LOAD;
                        state_n   = ST_GAP;
                    end else begin
                        err_p_n    = 1'b1;
                        err_code_n = ERR_TMO;
                        mode_n     = MODE_PD;
                        state_n    = ST_IDLE;
                    end
`else
                    err_p_n    = 1'b1;
                    err_code_n = ERR_TMO;
                    mode_n     = MODE_PD;
                    state_n    = ST_IDLE;
`endif
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State register: falling edge, async reset drives adpll_mode to PD at once
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            fcw        <= FCW_BASE;
            adpll_mode <= MODE_PD;
            cur_chan   <= '0;
            chan_lat   <= '0;
            mode_lat   <= MODE_PD;
            gap_cnt    <= '0;
            timer      <= '0;
            arm        <= 1'b0;
            done_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            err_code   <= ERR_NONE;
`ifdef ADPLL_SEQ_RETRY_EN
            retried    <= 1'b0;
`endif
        end else if (en) begin
            // NOTE: non-blocking assignments, so every register samples the pre-edge values.
            state      <= state_n;
            fcw        <= fcw_n;
            adpll_mode <= mode_n;
            cur_chan   <= cur_chan_n;
            chan_lat   <= chan_lat_n;
            mode_lat   <= mode_lat_n;
            gap_cnt    <= gap_cnt_n;
            timer      <= timer_n;
            arm        <= arm_n;
            done_pulse <= done_n;
            err_pulse  <= err_p_n;
            err_code   <= err_code_n;
`ifdef ADPLL_SEQ_RETRY_EN
            retried    <= retried_n;
`endif
        end
    end

endmodule

// File: tb/tb_adpll_chan_seq.sv
// -----------------------------------------------------------------------------
// tb_adpll_chan_seq
//   Directed bench for adpll_chan_seq. The DUT updates on the falling edge.
//   Inputs are driven and outputs sampled on the rising edge. Expected
//   apply results (gap length, fcw, mode, channel) are queued when a request
//   is driven and popped when the new mode appears.
//   Honours ADPLL_SEQ_RETRY_EN if the build defines it.
// -----------------------------------------------------------------------------
module tb_adpll_chan_seq;

    localparam logic [1:0] PD   = 2'd0;
    localparam logic [1:0] TEST = 2'd1;
    localparam logic [1:0] RX   = 2'd2;
    localparam logic [1:0] TX   = 2'd3;

`ifdef ADPLL_SEQ_RETRY_EN
    localparam int TMO_TO_ERR = 1024 + 4 + 1024;
`else
    localparam int TMO_TO_ERR = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_chan;
    logic [1:0]  req_mode;
    logic        channel_lock;
    logic [25:0] fcw;
    logic [1:0]  adpll_mode;
    logic        busy;
    logic        locked;
    logic        done_pulse;
    logic        err_pulse;
    logic [1:0]  err_code;
    logic [5:0]  cur_chan;

    adpll_chan_seq dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_chan     (req_chan),
        .req_mode     (req_mode),
        .channel_lock (channel_lock),
        .fcw          (fcw),
        .adpll_mode   (adpll_mode),
        .busy         (busy),
        .locked       (locked),
        .done_pulse   (done_pulse),
        .err_pulse    (err_pulse),
        .err_code     (err_code),
        .cur_chan     (cur_chan)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [31:0] fcw_of(input int chan);
        return 32'(1229824 + chan * 1024);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        assert (sb.size() > 0) else begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %0d expected a queued entry", obs);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, obs, e.val);
        end
    endtask

    // Queue what the DUT must show once a good RX/TX request is applied.
    task automatic push_apply(input int chan, input logic [1:0] mode);
        push_exp($sformatf("ch%0d_gap_len", chan), 32'd4);
        push_exp($sformatf("ch%0d_fcw", chan), fcw_of(chan));
        push_exp($sformatf("ch%0d_mode", chan), 32'(mode));
        push_exp($sformatf("ch%0d_cur_chan", chan), 32'(chan));
    endtask

    // Called on a rising edge; returns on the rising edge after the accepting negedge.
    task automatic send_req(input logic [5:0] chan, input logic [1:0] mode);
        check("req_ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_chan  = chan;
        req_mode  = mode;
        @(posedge clk);
        req_valid = 1'b0;
    endtask

    // Count PD cycles until the new mode shows, then pop the queued apply results.
    task automatic wait_apply();
        int n = 0;
        while (adpll_mode == PD && n < 50) begin
            n++;
            @(posedge clk);
        end
        pop_check(32'(n));
        pop_check(32'(fcw));
        pop_check(32'(adpll_mode));
        pop_check(32'(cur_chan));
    endtask

    initial begin
        int n;
        int dn;
        int g;

        rst          = 1'b1;
        en           = 1'b1;
        req_valid    = 1'b0;
        req_chan     = '0;
        req_mode     = PD;
        channel_lock = 1'b0;
        repeat (3) @(posedge clk);
        rst = 1'b0;
        @(posedge clk);

        // Reset values
        check("rst_fcw", 32'(fcw), fcw_of(0));
        check("rst_mode", 32'(adpll_mode), 32'd0);
        check("rst_cur_chan", 32'(cur_chan), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_done", 32'(done_pulse), 32'd0);
        check("rst_err_pulse", 32'(err_pulse), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);

        // RX channel 5, lock 600 cycles after apply
        push_apply(5, RX);
        send_req(6'd5, RX);
        wait_apply();
        check("t2_busy", 32'(busy), 32'd1);
        repeat (600) @(posedge clk);
        channel_lock = 1'b1;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            if (done_pulse) dn++;
        end
        check("t2_done_count", 32'(dn), 32'd1);
        check("t2_locked", 32'(locked), 32'd1);
        check("t2_cur_chan", 32'(cur_chan), 32'd5);
        check("t2_busy_after_lock", 32'(busy), 32'd0);

        // Lock loss, then re-acquire
        channel_lock = 1'b0;
        @(posedge clk);
        check("t5_err_pulse", 32'(err_pulse), 32'd1);
        check("t5_err_code", 32'(err_code), 32'd3);
        check("t5_locked", 32'(locked), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_fcw_kept", 32'(fcw), fcw_of(5));
        check("t5_mode_kept", 32'(adpll_mode), 32'(RX));
        @(posedge clk);
        channel_lock = 1'b1;
        @(posedge clk);
        check("t5_relock_done", 32'(done_pulse), 32'd1);
        check("t5_relock_locked", 32'(locked), 32'd1);

        // Lock drop in the same cycle as a new request: request wins
        channel_lock = 1'b0;
        push_apply(7, RX);
        send_req(6'd7, RX);
        check("t5b_no_err_pulse", 32'(err_pulse), 32'd0);
        check("t5b_err_code", 32'(err_code), 32'd0);
        check("t5b_busy", 32'(busy), 32'd1);
        check("t5b_mode_pd", 32'(adpll_mode), 32'(PD));
        wait_apply();
        @(posedge clk);
        channel_lock = 1'b1;
        @(posedge clk);
        check("t5b_done", 32'(done_pulse), 32'd1);
        check("t5b_locked", 32'(locked), 32'd1);

        // TX channel 10 with stale lock held high: no lock, timeout
        push_apply(10, TX);
        send_req(6'd10, TX);
        wait_apply();
        n  = 0;
        dn = 0;
        while (err_pulse !== 1'b1 && n < 2200) begin
            @(posedge clk);
            n++;
            if (done_pulse) dn++;
        end
        check("t3_cycles_to_err", 32'(n), 32'(TMO_TO_ERR));
        check("t3_no_done", 32'(dn), 32'd0);
        check("t3_err_code", 32'(err_code), 32'd1);
        check("t3_mode_pd", 32'(adpll_mode), 32'(PD));
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_ready", 32'(req_ready), 32'd1);
        @(posedge clk);

        // Bad requests: channel out of range, then TEST mode
        send_req(6'd40, RX);
        check("t4_chan40_err_pulse", 32'(err_pulse), 32'd1);
        check("t4_chan40_err_code", 32'(err_code), 32'd2);
        check("t4_chan40_fcw", 32'(fcw), fcw_of(10));
        check("t4_chan40_mode", 32'(adpll_mode), 32'(PD));
        check("t4_chan40_busy", 32'(busy), 32'd0);
        @(posedge clk);
        check("t4_pulse_clears", 32'(err_pulse), 32'd0);
        send_req(6'd3, TEST);
        check("t4_test_err_pulse", 32'(err_pulse), 32'd1);
        check("t4_test_err_code", 32'(err_code), 32'd2);
        check("t4_test_fcw", 32'(fcw), fcw_of(10));
        check("t4_test_cur_chan", 32'(cur_chan), 32'd10);
        check("t4_test_ready", 32'(req_ready), 32'd1);
        @(posedge clk);

        // PD request clears the sticky error
        send_req(6'd1, PD);
        check("pd_err_code", 32'(err_code), 32'd0);
        check("pd_err_pulse", 32'(err_pulse), 32'd0);
        check("pd_mode", 32'(adpll_mode), 32'(PD));
        check("pd_busy", 32'(busy), 32'd0);

        // Clock enable low: a valid request is not taken
        en        = 1'b0;
        req_valid = 1'b1;
        req_chan  = 6'd2;
        req_mode  = RX;
        @(posedge clk);
        check("en_low_no_accept", 32'(busy), 32'd0);
        req_valid = 1'b0;
        en        = 1'b1;
        @(posedge clk);

        // First attempt times out; retry build re-gaps and then locks
        channel_lock = 1'b0;
        push_apply(20, RX);
        send_req(6'd20, RX);
        wait_apply();
        n = 0;
        while (adpll_mode != PD && n < 1100) begin
            @(posedge clk);
            n++;
        end
        check("t6_cycles_to_tmo", 32'(n), 32'd1024);
`ifdef ADPLL_SEQ_RETRY_EN
        check("t6_no_err_pulse", 32'(err_pulse), 32'd0);
        check("t6_err_code", 32'(err_code), 32'd0);
        g = 0;
        while (adpll_mode == PD && g < 50) begin
            g++;
            @(posedge clk);
        end
        check("t6_retry_gap_len", 32'(g), 32'd4);
        check("t6_retry_fcw", 32'(fcw), fcw_of(20));
        check("t6_retry_mode", 32'(adpll_mode), 32'(RX));
        @(posedge clk);
        channel_lock = 1'b1;
        @(posedge clk);
        check("t6_retry_done", 32'(done_pulse), 32'd1);
        check("t6_retry_locked", 32'(locked), 32'd1);
`else
        g = 0;
        check("t6_err_pulse", 32'(err_pulse), 32'd1);
        check("t6_err_code", 32'(err_code), 32'd1);
        check("t6_idle_ready", 32'(req_ready), 32'd1);
        check("t6_busy", 32'(busy), 32'(g));
`endif
        @(posedge clk);

        // Highest legal channel, then async reset mid-WAIT_LOCK
        channel_lock = 1'b0;
        push_apply(39, TX);
        send_req(6'd39, TX);
        wait_apply();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t1_async_mode", 32'(adpll_mode), 32'(PD));
        check("t1_async_fcw", 32'(fcw), fcw_of(0));
        check("t1_async_busy", 32'(busy), 32'd0);
        @(posedge clk);
        rst = 1'b0;
        @(posedge clk);
        check("t1_ready", 32'(req_ready), 32'd1);
        check("t1_cur_chan", 32'(cur_chan), 32'd0);
        check("t1_err_code", 32'(err_code), 32'd0);
        check("t1_sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
